// File: rtl/hd_pkg.sv
// Shared parameters and types for the hyperdimensional encoding lanes.
// Sum width is sized so an N_SIZE-term signed dot product never overflows.
package hd_pkg;
  localparam int N_SIZE    = 32;
  localparam int FTWIDTH   = 8;
  localparam int DIM_WIDTH = 16;
  localparam int SUM_WIDTH = FTWIDTH + 1 + $clog2(N_SIZE);

  typedef logic        [FTWIDTH-1:0]   feature_t;
  typedef logic signed [DIM_WIDTH-1:0] dim_t;
endpackage

// File: rtl/signed_adder_tree.sv
// Balanced binary tree summing N signed IN_W-bit terms into OUT_W bits.
// Purely combinational; no flow control.
module signed_adder_tree #(
  parameter int N     = 32,
  parameter int IN_W  = 9,
  parameter int OUT_W = 14
) (
  input  logic [N-1:0][IN_W-1:0] terms,
  output logic [OUT_W-1:0]       sum
);
  localparam int LEVELS = $clog2(N);
  localparam int P      = 1 << LEVELS;

  // Heap layout: node i has children 2i+1 and 2i+2; leaves sit at P-1 .. 2P-2.
  logic signed [OUT_W-1:0] node [2*P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_term
      logic signed [IN_W-1:0] t;
      assign t           = terms[i];
      assign node[P-1+i] = OUT_W'(t);
    end else begin : g_pad
      assign node[P-1+i] = '0;
    end
  end

  for (genvar i = 0; i < P-1; i++) begin : g_add
    assign node[i] = node[2*i+1] + node[2*i+2];
  end

  assign sum = node[0];
endmodule

// File: rtl/mux_accumulator_32.sv
// One HD encoding lane: out <= prev_result + sum(+/-features by projection bit).
// One-cycle latency, accumulates every cycle; no backpressure, no enable.
module mux_accumulator_32
  import hd_pkg::*;
#(
  parameter int N_SIZE    = hd_pkg::N_SIZE,
  parameter int FTWIDTH   = hd_pkg::FTWIDTH,
  parameter int DIM_WIDTH = hd_pkg::DIM_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_SIZE-1:0][FTWIDTH-1:0]  features,
  input  logic [N_SIZE-1:0]               projections,
  input  logic [DIM_WIDTH-1:0]            prev_result,
  output logic [DIM_WIDTH-1:0]            out
);
  localparam int SUM_W = FTWIDTH + 1 + $clog2(N_SIZE);

  logic [N_SIZE-1:0][FTWIDTH:0] terms;
  logic [SUM_W-1:0]             sum;
  logic signed [SUM_W-1:0]      sum_s;
  logic [DIM_WIDTH-1:0]         next;

  for (genvar j = 0; j < N_SIZE; j++) begin : g_sign
    logic [FTWIDTH:0] mag;
    assign mag      = {1'b0, features[j]};
    assign terms[j] = projections[j] ? mag : ((FTWIDTH+1)'(0) - mag);
  end

  signed_adder_tree #(
    .N     (N_SIZE),
    .IN_W  (FTWIDTH + 1),
    .OUT_W (SUM_W)
  ) u_tree (
    .terms (terms),
    .sum   (sum)
  );

  // Size cast sign-extends or truncates the sum to the accumulator width.
  assign sum_s = sum;
  assign next  = prev_result + DIM_WIDTH'(sum_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= '0;
    else        out <= next;
  end
endmodule

// File: tb/tb_mux_accumulator_32.sv
// Randomized and directed bench for mux_accumulator_32 against an arithmetic model.
module tb_mux_accumulator_32;
  logic                 clk = 1'b0;
  logic                 reset;
  logic [31:0][7:0]     features;
  logic [31:0]          projections;
  logic [15:0]          prev_result;
  logic [15:0]          out;
  logic                 use_fb;
  logic [15:0]          ext_prev;
  logic [15:0]          exp_out;
  int                   total = 0;
  int                   bad = 0;

  mux_accumulator_32 dut (
    .clk         (clk),
    .reset       (reset),
    .features    (features),
    .projections (projections),
    .prev_result (prev_result),
    .out         (out)
  );

  always #5 clk = ~clk;

  assign prev_result = use_fb ? out : ext_prev;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, want);
    end
  endtask

  // Dot product of the signed projection row with the features, added modulo 2^16.
  function automatic logic [15:0] ref_next(input logic [15:0] prev, input logic [31:0] p,
                                           input logic [31:0][7:0] f);
    int acc;
    acc = int'(signed'(prev));
    for (int j = 0; j < 32; j++) begin
      if (p[j]) acc = acc + int'(f[j]);
      else      acc = acc - int'(f[j]);
    end
    return 16'(acc);
  endfunction

  task automatic cycle(input string tag, input logic fb, input logic [15:0] ext,
                       input logic [31:0] p, input logic [31:0][7:0] f);
    logic [15:0] pv;
    @(negedge clk);
    reset       = 1'b1;
    use_fb      = fb;
    ext_prev    = ext;
    projections = p;
    features    = f;
    pv          = fb ? exp_out : ext;
    exp_out     = ref_next(pv, p, f);
    @(posedge clk);
    #1;
    check(tag, out, exp_out);
  endtask

  initial begin
    logic [31:0][7:0] f;
    logic [31:0]      p;

    reset       = 1'b0;
    use_fb      = 1'b0;
    ext_prev    = 16'h1234;
    projections = $urandom;
    for (int j = 0; j < 32; j++) features[j] = 8'($urandom);
    exp_out = '0;
    #1;
    check("reset_immediate", out, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", out, 16'h0000);
    end

    // All +1: 32 per edge with feedback.
    for (int j = 0; j < 32; j++) f[j] = 8'd1;
    for (int k = 1; k <= 16; k++) begin
      cycle("all_plus_one", 1'b1, 16'h0, 32'hFFFF_FFFF, f);
      check("all_plus_one_const", out, 16'(32 * k));
    end

    // Asynchronous assert between edges.
    #2 reset = 1'b0;
    #1 check("async_reset", out, 16'h0000);
    exp_out = '0;
    @(posedge clk);
    #1 check("async_reset_hold", out, 16'h0000);

    cycle("all_minus_one", 1'b1, 16'h0, 32'h0, f);
    check("minus_32", out, 16'hFFE0);
    cycle("all_minus_one", 1'b1, 16'h0, 32'h0, f);
    check("minus_64", out, 16'hFFC0);
    cycle("all_minus_one", 1'b1, 16'h0, 32'h0, f);
    check("minus_96", out, 16'hFFA0);

    for (int j = 0; j < 32; j++) f[j] = 8'(j + 1);
    cycle("mixed_row", 1'b0, 16'd100, 32'h0000_FFFF, f);
    check("mixed_row_const", out, 16'hFF64);

    for (int j = 0; j < 32; j++) f[j] = 8'd255;
    cycle("wrap", 1'b0, 16'd32760, 32'hFFFF_FFFF, f);
    check("wrap_const", out, 16'h9FD8);
    cycle("max_neg", 1'b0, 16'd0, 32'h0, f);
    check("max_neg_const", out, 16'hE020);

    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 32; j++) f[j] = 8'($urandom);
      p = $urandom;
      if ((k % 37) == 5) p = '0;
      if ((k % 41) == 7) p = '1;
      cycle("random", 1'($urandom), 16'($urandom), p, f);
    end

    // Async reset mid random stream, then release with feedback: first result is 0 + sum.
    #3 reset = 1'b0;
    #1 check("async_reset_mid", out, 16'h0000);
    exp_out = '0;
    for (int j = 0; j < 32; j++) f[j] = 8'($urandom);
    p = $urandom;
    cycle("post_reset_first", 1'b1, 16'hBEEF, p, f);
    check("post_reset_sum", out, ref_next(16'h0, p, f));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
